// File: rtl/separable_conv_layer4_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : separable_conv_layer4_sequencer
// Brief   : Pulls one frame of 16-channel pixels into the layer-4 separable
//           convolution and counts its output beats until the frame completes.
// Rev     : 1.0  initial release
// ============================================================================
module separable_conv_layer4_sequencer #(
    parameter  int DATA_WIDHT    = 32,
    parameter  int IMG_WIDHT     = 44,
    parameter  int IMG_HEIGHT    = 44,
    parameter  int OUT_PIXELS    = 1936,
    parameter  int DRAIN_TIMEOUT = 4096,
    localparam int PIX_W = DATA_WIDHT * 16,
    localparam int COL_W = (IMG_WIDHT  > 1) ? $clog2(IMG_WIDHT)  : 1,
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1,
    localparam int CNT_W = $clog2(OUT_PIXELS + 1),
    localparam int TO_W  = $clog2(DRAIN_TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_src_valid,
    output logic             o_src_ready,
    input  logic [PIX_W-1:0] i_src_data,
    output logic [PIX_W-1:0] o_conv_data,
    output logic             o_conv_valid,
    input  logic             i_conv_valid_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err_timeout,
    output logic             o_err_overflow,
    output logic [COL_W-1:0] o_in_col,
    output logic [ROW_W-1:0] o_in_row,
    output logic [CNT_W-1:0] o_out_count
);

    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(IMG_WIDHT - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(OUT_PIXELS);
    localparam logic [TO_W-1:0]  c_TO_LIMIT = TO_W'(DRAIN_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FEED  = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PIX_W-1:0]   r_conv_data;
    logic               r_conv_valid;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [CNT_W-1:0]   r_out_count;
    logic [TO_W-1:0]    r_timeout;
    logic               r_err_timeout;
    logic               r_err_overflow;

    logic               w_accept;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_last_pix;
    logic               w_start;
    logic               w_in_frame;
    logic               w_cnt_inc;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [TO_W-1:0]    w_to_nxt;

    assign w_accept   = i_src_valid & (r_state == S_FEED);
    assign w_col_last = (r_col == c_COL_LAST);
    assign w_row_last = (r_row == c_ROW_LAST);
    assign w_last_pix = w_accept & w_col_last & w_row_last;
    assign w_start    = i_start & (r_state == S_IDLE);
    assign w_in_frame = (r_state == S_FEED) | (r_state == S_DRAIN);

    // Beats beyond the saturation point, or outside a frame, are never counted
    assign w_cnt_inc  = i_conv_valid_out & w_in_frame & (r_out_count != c_CNT_FULL);
    assign w_cnt_nxt  = r_out_count + CNT_W'(w_cnt_inc);
    assign w_to_nxt   = i_conv_valid_out ? '0 : r_timeout + TO_W'(1);

    // Exits from DRAIN look at the post-edge values so DONE/ERR follow the
    // triggering edge directly
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start)    w_state_nxt = S_FEED;
            S_FEED:  if (w_last_pix) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (w_cnt_nxt == c_CNT_FULL)     w_state_nxt = S_DONE;
                else if (w_to_nxt == c_TO_LIMIT) w_state_nxt = S_ERR;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_conv_data    <= '0;
            r_conv_valid   <= 1'b0;
            r_col          <= '0;
            r_row          <= '0;
            r_out_count    <= '0;
            r_timeout      <= '0;
            r_err_timeout  <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_conv_valid <= w_accept;
            if (w_accept) begin
                r_conv_data <= i_src_data;
            end
            if (w_start) begin
                r_col          <= '0;
                r_row          <= '0;
                r_out_count    <= '0;
                r_timeout      <= '0;
                r_err_timeout  <= 1'b0;
                r_err_overflow <= 1'b0;
            end else begin
                if (w_accept) begin
                    if (w_col_last) begin
                        r_col <= '0;
                        r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
                r_out_count <= w_cnt_nxt;
                if (r_state == S_DRAIN) begin
                    r_timeout <= w_to_nxt;
                end
                if (i_conv_valid_out & ~w_cnt_inc) begin
                    r_err_overflow <= 1'b1;
                end
                if ((r_state == S_DRAIN) && (w_state_nxt == S_ERR)) begin
                    r_err_timeout <= 1'b1;
                end
            end
        end
    end

    assign o_src_ready    = (r_state == S_FEED);
    assign o_busy         = w_in_frame;
    assign o_done         = (r_state == S_DONE);
    assign o_conv_data    = r_conv_data;
    assign o_conv_valid   = r_conv_valid;
    assign o_err_timeout  = r_err_timeout;
    assign o_err_overflow = r_err_overflow;
    assign o_in_col       = r_col;
    assign o_in_row       = r_row;
    assign o_out_count    = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_separable_conv_layer4_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_separable_conv_layer4_sequencer
// Brief   : Self-checking bench: directed vector table, frame-level sequences
//           and a cycle-level behavioural reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_separable_conv_layer4_sequencer;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int OP = 16;
    localparam int TO = 8;
    localparam int PW = DW * 16;
    localparam int NV = 36;

    localparam int P_IDLE  = 0;
    localparam int P_FEED  = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;
    localparam int P_ERR   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_src_valid = 1'b0;
    logic [PW-1:0] i_src_data = '0;
    logic          i_conv_valid_out = 1'b0;
    logic          o_src_ready;
    logic [PW-1:0] o_conv_data;
    logic          o_conv_valid;
    logic          o_busy;
    logic          o_done;
    logic          o_err_timeout;
    logic          o_err_overflow;
    logic [1:0]    o_in_col;
    logic [1:0]    o_in_row;
    logic [4:0]    o_out_count;

    always #5 clk = ~clk;

    separable_conv_layer4_sequencer #(
        .DATA_WIDHT    (DW),
        .IMG_WIDHT     (W),
        .IMG_HEIGHT    (H),
        .OUT_PIXELS    (OP),
        .DRAIN_TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (i_start),
        .i_src_valid      (i_src_valid),
        .o_src_ready      (o_src_ready),
        .i_src_data       (i_src_data),
        .o_conv_data      (o_conv_data),
        .o_conv_valid     (o_conv_valid),
        .i_conv_valid_out (i_conv_valid_out),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_err_timeout    (o_err_timeout),
        .o_err_overflow   (o_err_overflow),
        .o_in_col         (o_in_col),
        .o_in_row         (o_in_row),
        .o_out_count      (o_out_count)
    );

    // Reference model: frame phase plus a linear pixel index and beat tally
    int            m_ph = P_IDLE;
    int            m_pix = 0;
    int            m_beats = 0;
    int            m_silent = 0;
    bit            m_tmo = 1'b0;
    bit            m_ovf = 1'b0;
    bit            m_cv = 1'b0;
    bit            m_acc = 1'b0;
    logic [PW-1:0] m_cd = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = P_IDLE; m_pix = 0; m_beats = 0; m_silent = 0;
            m_tmo = 1'b0; m_ovf = 1'b0; m_cv = 1'b0; m_cd = '0;
        end else begin
            m_acc = i_src_valid && (m_ph == P_FEED);
            m_cv  = m_acc;
            if (m_acc) m_cd = i_src_data;
            case (m_ph)
                P_IDLE: begin
                    if (i_start) begin
                        m_ph = P_FEED; m_pix = 0; m_beats = 0; m_silent = 0;
                        m_tmo = 1'b0; m_ovf = 1'b0;
                    end else if (i_conv_valid_out) begin
                        m_ovf = 1'b1;
                    end
                end
                P_FEED, P_DRAIN: begin
                    if (i_conv_valid_out) begin
                        if (m_beats < OP) m_beats++;
                        else m_ovf = 1'b1;
                    end
                    if (m_ph == P_FEED) begin
                        if (m_acc) begin
                            m_pix++;
                            if (m_pix == W * H) begin
                                m_pix = 0;
                                m_ph  = P_DRAIN;
                            end
                        end
                    end else begin
                        m_silent = i_conv_valid_out ? 0 : m_silent + 1;
                        if (m_beats == OP) m_ph = P_DONE;
                        else if (m_silent == TO) begin
                            m_ph  = P_ERR;
                            m_tmo = 1'b1;
                        end
                    end
                end
                default: begin
                    if (i_conv_valid_out) m_ovf = 1'b1;
                    m_ph = P_IDLE;
                end
            endcase
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int cv_seen = 0;
    int done_seen = 0;

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Advance one cycle; outputs are compared against the model at the falling edge
    task automatic tick();
        @(negedge clk);
        chk("m_ready",  o_src_ready,    m_ph == P_FEED);
        chk("m_busy",   o_busy,         (m_ph == P_FEED) || (m_ph == P_DRAIN));
        chk("m_done",   o_done,         m_ph == P_DONE);
        chk("m_cv",     o_conv_valid,   m_cv);
        chk("m_cd",     o_conv_data,    m_cd);
        chk("m_col",    o_in_col,       m_pix % W);
        chk("m_row",    o_in_row,       m_pix / W);
        chk("m_cnt",    o_out_count,    m_beats);
        chk("m_tmo",    o_err_timeout,  m_tmo);
        chk("m_ovf",    o_err_overflow, m_ovf);
        if (o_conv_valid) cv_seen++;
        if (o_done)       done_seen++;
        #1;
    endtask

    function automatic logic [PW-1:0] pix(input int k);
        logic [PW-1:0] d;
        for (int c = 0; c < 16; c++) d[c*DW +: DW] = 8'(k * 16 + c + 1);
        return d;
    endfunction

    function automatic logic [PW-1:0] rpix();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One full frame: start pulse, feed with pct% valid, then nbeats outputs
    task automatic frame(input int pct, input bit poke, input int nbeats,
                         output int cv_d, output int dn_d, output int lat);
        int cv0, dn0, guard, sent, gap, t_beat, t_err;
        cv0 = cv_seen; dn0 = done_seen;
        i_start = 1'b1; i_src_valid = 1'b0; i_conv_valid_out = 1'b0;
        tick();
        i_start = 1'b0;
        chk("start_clears_tmo", o_err_timeout, 1'b0);
        chk("start_clears_ovf", o_err_overflow, 1'b0);
        guard = 0;
        while (m_ph != P_DRAIN && guard < 1000) begin
            i_src_valid = ($urandom_range(99) < pct);
            i_src_data  = rpix();
            i_start     = poke && ($urandom_range(3) == 0);
            tick();
            guard++;
        end
        chk("feed_budget", guard < 1000, 1'b1);
        i_start = 1'b0;
        sent = 0; gap = 0; guard = 0; t_beat = -100; t_err = -1;
        while (m_ph != P_IDLE && guard < 200) begin
            if (o_err_timeout && t_err < 0) t_err = guard;
            i_src_valid = $urandom_range(1);
            i_src_data  = rpix();
            i_conv_valid_out = (sent < nbeats) &&
                               (sent >= OP || gap >= 2 || $urandom_range(1) == 1);
            if (i_conv_valid_out) begin
                sent++; gap = 0;
                if (sent == nbeats) t_beat = guard;
            end else begin
                gap++;
            end
            tick();
            guard++;
        end
        chk("drain_budget", guard < 200, 1'b1);
        i_conv_valid_out = 1'b0; i_src_valid = 1'b0;
        cv_d = cv_seen - cv0;
        dn_d = done_seen - dn0;
        lat  = t_err - t_beat;
    endtask

    typedef struct {
        bit            st, sv, vo;
        logic [PW-1:0] d;
        bit            e_rdy, e_busy, e_done, e_cv;
        logic [PW-1:0] e_cd;
        int            e_col, e_row, e_cnt;
    } vec_t;

    vec_t tbl [NV];

    initial begin
        int cv_d, dn_d, lat, g;

        for (int i = 0; i < NV; i++) begin
            tbl[i].st     = (i == 0);
            tbl[i].sv     = (i >= 1 && i <= 16);
            tbl[i].d      = pix(i - 1);
            tbl[i].vo     = (i >= 17 && i <= 32);
            tbl[i].e_rdy  = (i >= 1 && i <= 16);
            tbl[i].e_busy = (i >= 1 && i <= 32);
            tbl[i].e_done = (i == 33);
            tbl[i].e_cv   = (i >= 2 && i <= 17);
            tbl[i].e_cd   = (i >= 2 && i <= 17) ? pix(i - 2) : ((i > 17) ? pix(15) : '0);
            tbl[i].e_col  = (i >= 1 && i <= 16) ? (i - 1) % W : 0;
            tbl[i].e_row  = (i >= 1 && i <= 16) ? (i - 1) / W : 0;
            tbl[i].e_cnt  = (i <= 17) ? 0 : ((i <= 33) ? i - 17 : OP);
        end

        repeat (3) tick();
        chk("rst_ready", o_src_ready, 1'b0);
        chk("rst_cv",    o_conv_valid, 1'b0);
        chk("rst_cd",    o_conv_data, '0);
        chk("rst_busy",  o_busy, 1'b0);
        chk("rst_done",  o_done, 1'b0);
        rst_n = 1'b1;

        // Back-to-back frame, all pixels offered, 16 consecutive output beats
        for (int i = 0; i < NV; i++) begin
            i_start = tbl[i].st; i_src_valid = tbl[i].sv;
            i_src_data = tbl[i].d; i_conv_valid_out = tbl[i].vo;
            chk($sformatf("v%0d_ready", i), o_src_ready,  tbl[i].e_rdy);
            chk($sformatf("v%0d_busy", i),  o_busy,       tbl[i].e_busy);
            chk($sformatf("v%0d_done", i),  o_done,       tbl[i].e_done);
            chk($sformatf("v%0d_cv", i),    o_conv_valid, tbl[i].e_cv);
            chk($sformatf("v%0d_cd", i),    o_conv_data,  tbl[i].e_cd);
            chk($sformatf("v%0d_col", i),   o_in_col,     tbl[i].e_col);
            chk($sformatf("v%0d_row", i),   o_in_row,     tbl[i].e_row);
            chk($sformatf("v%0d_cnt", i),   o_out_count,  tbl[i].e_cnt);
            tick();
        end
        i_start = 1'b0; i_src_valid = 1'b0; i_conv_valid_out = 1'b0;

        frame(50, 1'b0, OP, cv_d, dn_d, lat);
        chk("gaps_cv_beats", cv_d, OP);
        chk("gaps_done_pulses", dn_d, 1);
        chk("gaps_no_ovf", o_err_overflow, 1'b0);

        i_conv_valid_out = 1'b1;
        tick();
        i_conv_valid_out = 1'b0;
        chk("idle_beat_ovf", o_err_overflow, 1'b1);
        tick();

        frame(70, 1'b0, 10, cv_d, dn_d, lat);
        chk("tmo_cv_beats", cv_d, OP);
        chk("tmo_no_done", dn_d, 0);
        chk("tmo_flag", o_err_timeout, 1'b1);
        chk("tmo_latency", lat, TO + 1);
        chk("tmo_cnt", o_out_count, 10);

        frame(100, 1'b0, OP + 1, cv_d, dn_d, lat);
        chk("ovf_cnt_sat", o_out_count, OP);
        chk("ovf_flag", o_err_overflow, 1'b1);
        chk("ovf_done_pulses", dn_d, 1);

        frame(60, 1'b1, OP, cv_d, dn_d, lat);
        chk("poke_cv_beats", cv_d, OP);
        chk("poke_done_pulses", dn_d, 1);

        // Asynchronous reset in the middle of the feed
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        g = 0;
        while (m_pix < 7 && g < 50) begin
            i_src_valid = 1'b1; i_src_data = rpix();
            tick();
            g++;
        end
        i_src_valid = 1'b0;
        chk("pre_rst_cv", o_conv_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cv",    o_conv_valid, 1'b0);
        chk("arst_cd",    o_conv_data, '0);
        chk("arst_ready", o_src_ready, 1'b0);
        chk("arst_busy",  o_busy, 1'b0);
        chk("arst_col",   o_in_col, 0);
        chk("arst_row",   o_in_row, 0);
        chk("arst_cnt",   o_out_count, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        frame(100, 1'b0, OP, cv_d, dn_d, lat);
        chk("post_rst_cv_beats", cv_d, OP);
        chk("post_rst_done", dn_d, 1);

        for (int r = 0; r < 6; r++) begin
            int nb;
            nb = (r % 3 == 0) ? OP : ((r % 3 == 1) ? 12 : OP + 1);
            frame($urandom_range(100, 20), 1'($urandom_range(1)), nb, cv_d, dn_d, lat);
            chk($sformatf("rnd%0d_cv_beats", r), cv_d, OP);
            chk($sformatf("rnd%0d_done", r), dn_d, (nb >= OP) ? 1 : 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
